// File: rtl/intadd_acc.sv
// Saturating per-lane integer accumulator that reduces a stream of adder-stage
// beats and counts compare flags across lanes, with a valid/ready handshake on both sides.
module intadd_acc #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      cfg_len,
  input  logic                  cfg_sign,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_dst,
  input  logic [32*LANES-1:0]   in_st,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_acc,
  output logic [CNT_W-1:0]      out_lt_cnt,
  output logic [CNT_W-1:0]      out_eq_cnt,
  output logic [CNT_W-1:0]      out_gt_cnt,
  output logic [CNT_W-1:0]      out_beats,
  output logic                  busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int POP_W = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + POP_W;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       len_q, len_d;
  logic                   sign_q, sign_d;
  logic [LANES-1:0][31:0] acc_q, acc_d;
  logic [CNT_W-1:0]       lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic [CNT_W-1:0]       beats_q, beats_d;

  logic                   accept;
  logic                   final_beat;
  logic [CNT_W:0]         beats_inc;
  logic [CNT_W:0]         eff_len;
  logic [POP_W-1:0]       pop_lt, pop_eq, pop_gt;
  logic                   unused_st;

  // Overflow is judged on a 33-bit sum: sign-extended operands in signed mode,
  // zero-extended in unsigned mode.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic [32:0] s;
    if (sgn) begin
      s = {a[31], a} + {b[31], b};
      if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      s = {1'b0, a} + {1'b0, b};
      if (s[32]) return 32'hFFFF_FFFF;
    end
    return s[31:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c,
                                               input logic [POP_W-1:0] p);
    logic [SUM_W-1:0] s;
    s = SUM_W'(c) + SUM_W'(p);
    return (s > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign accept     = in_valid && (state_q == ACC);
  assign beats_inc  = {1'b0, beats_q} + {{CNT_W{1'b0}}, 1'b1};
  assign eff_len    = (len_q == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, len_q};
  assign final_beat = in_last || (beats_inc >= eff_len);
  assign unused_st  = ^in_st;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    pop_lt = '0;
    pop_eq = '0;
    pop_gt = '0;
    for (int i = 0; i < LANES; i++) begin
      pop_lt = pop_lt + POP_W'(in_st[32*i]);
      pop_eq = pop_eq + POP_W'(in_st[32*i+1]);
      pop_gt = pop_gt + POP_W'(in_st[32*i+2]);
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    beats_d = beats_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          len_d   = cfg_len;
          sign_d  = cfg_sign;
          acc_d   = '0;
          lt_d    = '0;
          eq_d    = '0;
          gt_d    = '0;
          beats_d = '0;
        end
      end
      ACC: begin
        if (accept) begin
          for (int i = 0; i < LANES; i++) begin
            acc_d[i] = sat_add(acc_q[i], in_dst[32*i +: 32], sign_q);
          end
          lt_d    = sat_cnt(lt_q, pop_lt);
          eq_d    = sat_cnt(eq_q, pop_eq);
          gt_d    = sat_cnt(gt_q, pop_gt);
          beats_d = beats_inc[CNT_W-1:0];
          if (final_beat) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  // The accumulators are plain registers, cleared by reset because the outputs
  // must read zero while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      lt_q    <= '0;
      eq_q    <= '0;
      gt_q    <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      beats_q <= beats_d;
    end
  end

  assign in_ready   = (state_q == ACC);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_acc    = acc_q;
  assign out_lt_cnt = lt_q;
  assign out_eq_cnt = eq_q;
  assign out_gt_cnt = gt_q;
  assign out_beats  = beats_q;

endmodule

// File: tb/tb_intadd_acc.sv
// Randomised self-checking bench for intadd_acc against an arithmetic reference
// model of the lane sums, flag counts and handshake timing.
module tb_intadd_acc;

  localparam int LANES = 4;
  localparam int CNT_W = 16;
  localparam int W     = 32 * LANES;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] cfg_len;
  logic             cfg_sign;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_dst;
  logic [W-1:0]     in_st;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_acc;
  logic [CNT_W-1:0] out_lt_cnt, out_eq_cnt, out_gt_cnt, out_beats;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] q_dst[$];
  logic [W-1:0] q_st[$];

  logic [31:0] m_acc[LANES];
  int          m_lt, m_eq, m_gt, m_beats;

  intadd_acc #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_sign  (cfg_sign),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dst    (in_dst),
    .in_st     (in_st),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_lt_cnt(out_lt_cnt),
    .out_eq_cnt(out_eq_cnt),
    .out_gt_cnt(out_gt_cnt),
    .out_beats (out_beats),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input bit sgn);
    longint s;
    if (sgn) begin
      s = longint'($signed(a)) + longint'($signed(b));
      if (s > 64'sd2147483647)  s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
    end else begin
      s = longint'(a) + longint'(b);
      if (s > 64'sd4294967295) s = 64'sd4294967295;
    end
    return s[31:0];
  endfunction

  function automatic int flag_pop(input logic [W-1:0] st, input int pos);
    int n = 0;
    for (int l = 0; l < LANES; l++) n += int'(st[32*l+pos]);
    return n;
  endfunction

  task automatic model_clear();
    for (int l = 0; l < LANES; l++) m_acc[l] = '0;
    m_lt = 0; m_eq = 0; m_gt = 0; m_beats = 0;
  endtask

  task automatic model_beat(input logic [W-1:0] d, input logic [W-1:0] st, input bit sgn);
    for (int l = 0; l < LANES; l++) m_acc[l] = ref_add(m_acc[l], d[32*l +: 32], sgn);
    m_lt = (m_lt + flag_pop(st, 0) > CMAX) ? CMAX : m_lt + flag_pop(st, 0);
    m_eq = (m_eq + flag_pop(st, 1) > CMAX) ? CMAX : m_eq + flag_pop(st, 1);
    m_gt = (m_gt + flag_pop(st, 2) > CMAX) ? CMAX : m_gt + flag_pop(st, 2);
    m_beats++;
  endtask

  task automatic check_results(input string tag);
    for (int l = 0; l < LANES; l++)
      check($sformatf("%s_acc%0d", tag, l), 64'(out_acc[32*l +: 32]), 64'(m_acc[l]));
    check({tag, "_lt"},    64'(out_lt_cnt), 64'(m_lt));
    check({tag, "_eq"},    64'(out_eq_cnt), 64'(m_eq));
    check({tag, "_gt"},    64'(out_gt_cnt), 64'(m_gt));
    check({tag, "_beats"}, 64'(out_beats),  64'(m_beats));
  endtask

  // gap_mode: 0 = in_valid always high, 1 = toggles each cycle, 2 = random
  task automatic run_red(input int len, input bit sgn, input int last_at,
                         input int gap_mode, input int hold);
    int eff, n_exp, idx, cyc;
    eff   = (len == 0) ? 1 : len;
    n_exp = (last_at > 0 && last_at < eff) ? last_at : eff;
    @(negedge clk);
    check("idle_ready", 64'(in_ready), 64'd0);
    start = 1'b1; cfg_len = CNT_W'(len); cfg_sign = sgn;
    @(negedge clk);
    start = 1'b0; cfg_len = CNT_W'($urandom); cfg_sign = ~sgn;
    check("start_busy",  64'(busy), 64'd1);
    check("start_ready", 64'(in_ready), 64'd1);
    check("start_beats", 64'(out_beats), 64'd0);
    model_clear();
    idx = 0; cyc = 0;
    while (idx < n_exp && cyc < 90000) begin
      case (gap_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom_range(2) != 0);
      endcase
      in_dst    = q_dst[idx];
      in_st     = q_st[idx];
      in_last   = (idx + 1 == last_at);
      start     = ($urandom_range(3) == 0);
      out_ready = $urandom_range(1);
      @(posedge clk);
      if (in_valid) begin
        model_beat(q_dst[idx], q_st[idx], sgn);
        idx++;
      end
      @(negedge clk);
      cyc++;
      if (idx < n_exp) check("acc_no_valid", 64'(out_valid), 64'd0);
    end
    if (idx < n_exp) check("beat_timeout", 64'(idx), 64'(n_exp));
    start = 1'b0; out_ready = 1'b0; in_last = 1'b0;
    check("done_valid", 64'(out_valid), 64'd1);
    check("done_ready", 64'(in_ready), 64'd0);
    check("done_busy",  64'(busy), 64'd1);
    check_results("done");
    in_valid = 1'b1;
    in_dst   = {$urandom, $urandom, $urandom, $urandom};
    in_st    = {$urandom, $urandom, $urandom, $urandom};
    for (int h = 0; h < hold; h++) begin
      start = $urandom_range(1);
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
      check_results("hold");
    end
    out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("hs_valid", 64'(out_valid), 64'd0);
    check("hs_busy",  64'(busy), 64'd0);
    check_results("idle");
    @(negedge clk);
    check("hs_start_ignored", 64'(busy), 64'd0);
    q_dst.delete();
    q_st.delete();
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      q_dst.push_back({$urandom, $urandom, $urandom, $urandom});
      q_st.push_back({$urandom, $urandom, $urandom, $urandom});
    end
  endtask

  initial begin
    int len, last_at;
    rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_sign = 1'b0;
    in_valid = 1'b0; in_dst = '0; in_st = '0; in_last = 1'b0; out_ready = 1'b0;
    #3;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_acc",   64'(out_acc[63:0]), 64'd0);
    check("rst_beats", 64'(out_beats), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned reduction of 1, 2, 3 on every lane with the equal flag set
    for (int k = 1; k <= 3; k++) begin
      q_dst.push_back({LANES{32'(k)}});
      q_st.push_back({LANES{32'h0000_0002}});
    end
    run_red(3, 1'b0, 0, 0, 2);
    check("dir_lane0_sum", 64'(out_acc[31:0]), 64'd6);
    check("dir_eq_cnt",    64'(out_eq_cnt), 64'd12);

    // Signed saturation in both directions
    q_dst.push_back({32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFF0});
    q_dst.push_back({32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFF0, 32'h0000_0020});
    q_st.push_back('0);
    q_st.push_back({LANES{32'h0000_0005}});
    run_red(2, 1'b1, 0, 0, 1);
    check("sat_pos", 64'(out_acc[31:0]),  64'h7FFF_FFFF);
    check("sat_neg", 64'(out_acc[63:32]), 64'h8000_0000);
    check("neg_sum", 64'(out_acc[95:64]), 64'h0000_0000);

    // Unsigned saturation
    for (int k = 0; k < 4; k++) begin
      q_dst.push_back({LANES{32'hFFFF_0000}});
      q_st.push_back('0);
    end
    run_red(4, 1'b0, 0, 2, 0);
    check("sat_uns", 64'(out_acc[127:96]), 64'hFFFF_FFFF);

    // Early end via in_last on beat 2 of 8
    fill_random(8);
    run_red(8, 1'b1, 2, 2, 1);
    check("early_beats", 64'(out_beats), 64'd2);

    // Toggling in_valid and five cycles of output backpressure
    fill_random(5);
    run_red(5, 1'b0, 0, 1, 5);

    // Random reductions
    for (int t = 0; t < 12; t++) begin
      len     = ($urandom_range(5) == 0) ? 0 : $urandom_range(1, 12);
      last_at = ($urandom_range(2) == 0) ? $urandom_range(1, 12) : 0;
      fill_random(13);
      run_red(len, $urandom_range(1), last_at, $urandom_range(2), $urandom_range(3));
    end

    // Reset in the middle of a cfg_len=4 reduction
    @(negedge clk);
    start = 1'b1; cfg_len = 16'd4; cfg_sign = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    in_dst = {LANES{32'h0000_0011}}; in_st = {LANES{32'h0000_0007}};
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_beat1", 64'(out_beats), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_acc",   64'(out_acc[63:0]), 64'd0);
    check("abort_lt",    64'(out_lt_cnt), 64'd0);
    check("abort_beats", 64'(out_beats), 64'd0);
    check("abort_busy",  64'(busy), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_valid", 64'(out_valid), 64'd0);
    end
    fill_random(1);
    run_red(0, 1'b1, 0, 0, 1);
    check("len0_beats", 64'(out_beats), 64'd1);

    // Flag counters saturate at 2^CNT_W-1
    for (int i = 0; i < 16400; i++) begin
      q_dst.push_back({$urandom, $urandom, $urandom, $urandom});
      q_st.push_back({LANES{32'h0000_0007}});
    end
    run_red(16400, 1'b0, 0, 0, 1);
    check("cnt_sat_lt", 64'(out_lt_cnt), 64'(CMAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
